ascon_serial_host: RTL and testbench
====================================

Name: ascon_serial_host

Overview:
- Host-side driver for the bit-serial interface of the Ascon encryption top.
- Accepts a job as parallel words: three shares each of key, nonce, AD and PT, plus fault and mask randomness.
- Resets the encryption top, shifts every stream in MSB-first, pulses start, then deserialises the LSB-first ciphertext and tag streams back into parallel words.
- Used by system integration logic and as the bench-side transactor for the encryption top.

Parameters:
- K, 128, key length in bits.
- L, 32, associated-data length in bits.
- Y, 32, plaintext/ciphertext length in bits.
- TIMEOUT, 4096, maximum cycles in WAIT before the job is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- key_sh  in  3*K  key shares; share n at [n*K +: K].
- nonce_sh  in  384  nonce shares; share n at [n*128 +: 128].
- ad_sh  in  3*L  AD shares.
- pt_sh  in  3*Y  PT shares.
- r64  in  448  mask randomness; lane n at [n*64 +: 64].
- r128  in  128  fault randomness, 128-bit stream.
- rpt  in  Y  fault randomness, PT-length stream.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  job aborted; valid while done=1, then held.
- cipher_text  out  Y  captured ciphertext.
- tag  out  128  captured tag.
- dut_rst  out  1  synchronous reset to the encryption top.
- keyxSO, noncexSO, adxSO, ptxSO  out  3 each  serial share bits; bit n = share n.
- r64xSO  out  7  serial mask bits.
- r128xSO, rptxSO  out  1 each  serial fault bits.
- enc_startxSO  out  1  start strobe to the encryption top.
- enc_readyxSI, ctxSI, tagxSI  in  1 each  ready and serial result bits from the encryption top.

Behaviour:
- Reset values: state=IDLE, dut_rst=1, busy=0, done=0, err=0, cipher_text=0, tag=0, every serial output 0, counters 0.
- Constants: M = max(K,128,L,Y); R = max(Y,128). Counters are 16 bits wide.
- Asynchronous reset mid-job returns to IDLE immediately and discards the job.
- IDLE: dut_rst=1. On start=1, register all parallel inputs (later input changes are ignored) and go to RST_DUT. start while busy is ignored.
- RST_DUT, 1 cycle: dut_rst=1, scnt=0, then go to SHIFT.
- SHIFT: dut_rst=0.
  - Each stream of length N drives bit N-1-scnt while scnt<N, else 0.
  - Lengths: key K, nonce and r128 128, AD L, PT and rpt Y, r64 lanes 64.
  - Stay for M+1 cycles (scnt 0..M); the extra cycle satisfies the encryption top's ready condition (count > M). Then go to START.
- START, 1 cycle: enc_startxSO=1, serial outputs 0, then go to WAIT with wcnt=0.
- WAIT:
  - First edge sampling enc_readyxSI=1 → go to RECV with rcnt=0.
  - wcnt reaches TIMEOUT → err=1, go to DONE.
- RECV:
  - Each edge: if rcnt<Y, cipher_text[rcnt]<=ctxSI; if rcnt<128, tag[rcnt]<=tagxSI; rcnt++.
  - The first capture edge is the one after ready is first sampled, matching the encryption top's one-cycle registered output.
  - After R captures, go to DONE.
  - enc_readyxSI sampled 0 during RECV → err=1, go to DONE.
- DONE, 1 cycle: done=1, then go to IDLE with dut_rst reasserted.
- cipher_text, tag and err hold until the next job's RST_DUT cycle, where they clear to 0.
- Job length without timeout: 1+(M+1)+1+W+R+1 cycles, where W is the encryption top's latency.

Test Plan:
- Default params; key share0=0x000102..0F, other shares 0, nonce 0, AD 0x00000001, PT 0x00000000, randomness 0 → keyxSO[0] carries bit127..bit0 on SHIFT cycles 0..127 and is 0 on cycle 128. enc_startxSO is high exactly 1 cycle after 129 SHIFT cycles.
- Behavioural encryption-top model returns CT=0xA5A5_3C3C, tag=0x0123...EF LSB-first one cycle after ready → cipher_text/tag match exactly; done pulses once; err=0.
- Model never raises ready, TIMEOUT=16 → done with err=1 exactly 16 cycles after START.
- Model drops ready at rcnt=40 → done with err=1; cipher_text holds its full captured value; tag bits 0..39 are captured.
- rst asserted mid-SHIFT (scnt=50) → same cycle: IDLE, dut_rst=1, busy=0. A new start then runs a clean job with matching results.
- start held high for a whole job plus pt_sh changed during SHIFT → the job uses the originally latched PT; a second job begins right after DONE.

Source files
------------

// File: rtl/ascon_serial_host.sv
// ascon_serial_host: host-side transactor for the bit-serial Ascon encryption top.
// A job is latched in parallel form, every stream is shifted out MSB-first, the
// top is started, and the LSB-first ciphertext and tag streams are collected back.
module ascon_serial_host #(
  parameter int K       = 128,
  parameter int L       = 32,
  parameter int Y       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3*K-1:0]   key_sh,
  input  logic [383:0]     nonce_sh,
  input  logic [3*L-1:0]   ad_sh,
  input  logic [3*Y-1:0]   pt_sh,
  input  logic [447:0]     r64,
  input  logic [127:0]     r128,
  input  logic [Y-1:0]     rpt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [Y-1:0]     cipher_text,
  output logic [127:0]     tag,
  output logic             dut_rst,
  output logic [2:0]       keyxSO,
  output logic [2:0]       noncexSO,
  output logic [2:0]       adxSO,
  output logic [2:0]       ptxSO,
  output logic [6:0]       r64xSO,
  output logic             r128xSO,
  output logic             rptxSO,
  output logic             enc_startxSO,
  input  logic             enc_readyxSI,
  input  logic             ctxSI,
  input  logic             tagxSI
);

  // Longest serial stream sets the SHIFT length; longest result stream sets RECV length.
  localparam int M0 = (K > 128) ? K : 128;
  localparam int M1 = (M0 > L) ? M0 : L;
  localparam int M  = (M1 > Y) ? M1 : Y;
  localparam int R  = (Y > 128) ? Y : 128;
  localparam int YW = (Y > 1) ? $clog2(Y) : 1;

  localparam logic [15:0] SCNT_LAST = 16'(M);
  localparam logic [15:0] RCNT_LAST = 16'(R - 1);
  localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] Y_LEN     = 16'(Y);
  localparam logic [15:0] TAG_LEN   = 16'd128;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_DUT, S_SHIFT, S_START, S_WAIT, S_RECV, S_DONE
  } state_t;

  state_t      state;
  logic [15:0] scnt, wcnt, rcnt;

  // Latched job, one shift register per share; the MSB is always the next bit out.
  logic [2:0][K-1:0]   key_sr;
  logic [2:0][127:0]   nonce_sr;
  logic [2:0][L-1:0]   ad_sr;
  logic [2:0][Y-1:0]   pt_sr;
  logic [6:0][63:0]    r64_sr;
  logic [127:0]        r128_sr;
  logic [Y-1:0]        rpt_sr;

  logic load, shift_en;

  // The RST_DUT edge presents bit 0 of every stream, each SHIFT edge the next one;
  // the final SHIFT cycle (scnt==M) drives zeros.
  assign load     = (state == S_IDLE) && start;
  assign shift_en = (state == S_RST_DUT) || ((state == S_SHIFT) && (scnt != SCNT_LAST));

  // Serial datapath: latch on accept, shift MSB-first into registered serial outputs.
  // Streams shorter than M run out of ones and drive 0 on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sr   <= '0;
      nonce_sr <= '0;
      ad_sr    <= '0;
      pt_sr    <= '0;
      r64_sr   <= '0;
      r128_sr  <= '0;
      rpt_sr   <= '0;
      keyxSO   <= '0;
      noncexSO <= '0;
      adxSO    <= '0;
      ptxSO    <= '0;
      r64xSO   <= '0;
      r128xSO  <= 1'b0;
      rptxSO   <= 1'b0;
    end else if (load) begin
      key_sr   <= key_sh;
      nonce_sr <= nonce_sh;
      ad_sr    <= ad_sh;
      pt_sr    <= pt_sh;
      r64_sr   <= r64;
      r128_sr  <= r128;
      rpt_sr   <= rpt;
    end else if (shift_en) begin
      for (int n = 0; n < 3; n++) begin
        keyxSO[n]   <= key_sr[n][K-1];
        key_sr[n]   <= {key_sr[n][K-2:0], 1'b0};
        noncexSO[n] <= nonce_sr[n][127];
        nonce_sr[n] <= {nonce_sr[n][126:0], 1'b0};
        adxSO[n]    <= ad_sr[n][L-1];
        ad_sr[n]    <= {ad_sr[n][L-2:0], 1'b0};
        ptxSO[n]    <= pt_sr[n][Y-1];
        pt_sr[n]    <= {pt_sr[n][Y-2:0], 1'b0};
      end
      for (int n = 0; n < 7; n++) begin
        r64xSO[n] <= r64_sr[n][63];
        r64_sr[n] <= {r64_sr[n][62:0], 1'b0};
      end
      r128xSO <= r128_sr[127];
      r128_sr <= {r128_sr[126:0], 1'b0};
      rptxSO  <= rpt_sr[Y-1];
      rpt_sr  <= {rpt_sr[Y-2:0], 1'b0};
    end else begin
      keyxSO   <= '0;
      noncexSO <= '0;
      adxSO    <= '0;
      ptxSO    <= '0;
      r64xSO   <= '0;
      r128xSO  <= 1'b0;
      rptxSO   <= 1'b0;
    end
  end

  // Job sequencer with registered control outputs and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      dut_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cipher_text  <= '0;
      tag          <= '0;
      enc_startxSO <= 1'b0;
      scnt         <= '0;
      wcnt         <= '0;
      rcnt         <= '0;
    end else begin
      done         <= 1'b0;
      enc_startxSO <= 1'b0;
      case (state)
        S_IDLE: begin
          dut_rst <= 1'b1;
          if (start) begin
            state       <= S_RST_DUT;
            busy        <= 1'b1;
            err         <= 1'b0;
            cipher_text <= '0;
            tag         <= '0;
            scnt        <= '0;
          end
        end
        S_RST_DUT: begin
          dut_rst <= 1'b0;
          scnt    <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          // One cycle beyond the longest stream so the top sees count > M.
          if (scnt == SCNT_LAST) begin
            state        <= S_START;
            enc_startxSO <= 1'b1;
          end else begin
            scnt <= scnt + 16'd1;
          end
        end
        S_START: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Ready wins over timeout when both land on the same edge.
          if (enc_readyxSI) begin
            rcnt  <= '0;
            state <= S_RECV;
          end else if (wcnt == WCNT_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_RECV: begin
          // Ready must stay high for the whole result burst; a drop aborts without capture.
          if (!enc_readyxSI) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            if (rcnt < Y_LEN)   cipher_text[rcnt[YW-1:0]] <= ctxSI;
            if (rcnt < TAG_LEN) tag[rcnt[6:0]]            <= tagxSI;
            rcnt <= rcnt + 16'd1;
            if (rcnt == RCNT_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          dut_rst <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed bench for ascon_serial_host with a behavioural encryption-top model.
module tb_ascon_serial_host;

  localparam int K = 128;
  localparam int L = 32;
  localparam int Y = 32;
  localparam int TO = 16;
  localparam int MDLY = 3;   // model edges between start and ready -> W = MDLY+2 WAIT cycles

  localparam logic [31:0]  CT   = 32'hA5A5_3C3C;
  localparam logic [127:0] TAGV = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3*K-1:0] key_sh = '0;
  logic [383:0]   nonce_sh = '0;
  logic [3*L-1:0] ad_sh = '0;
  logic [3*Y-1:0] pt_sh = '0;
  logic [447:0]   r64 = '0;
  logic [127:0]   r128 = '0;
  logic [Y-1:0]   rpt = '0;
  logic busy, done, err, dut_rst;
  logic [Y-1:0] cipher_text;
  logic [127:0] tag;
  logic [2:0] keyxSO, noncexSO, adxSO, ptxSO;
  logic [6:0] r64xSO;
  logic r128xSO, rptxSO, enc_startxSO;
  logic enc_readyxSI = 1'b0;
  logic ctxSI = 1'b0;
  logic tagxSI = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;  // 0 normal, 1 never ready, 2 drop ready at output bit 40

  ascon_serial_host #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .key_sh(key_sh), .nonce_sh(nonce_sh), .ad_sh(ad_sh), .pt_sh(pt_sh),
    .r64(r64), .r128(r128), .rpt(rpt),
    .busy(busy), .done(done), .err(err),
    .cipher_text(cipher_text), .tag(tag), .dut_rst(dut_rst),
    .keyxSO(keyxSO), .noncexSO(noncexSO), .adxSO(adxSO), .ptxSO(ptxSO),
    .r64xSO(r64xSO), .r128xSO(r128xSO), .rptxSO(rptxSO),
    .enc_startxSO(enc_startxSO),
    .enc_readyxSI(enc_readyxSI), .ctxSI(ctxSI), .tagxSI(tagxSI)
  );

  always #5 clk = ~clk;

  // Encryption-top model: ready after a fixed latency, then LSB-first CT/tag one cycle later.
  int m_st = 0;
  int m_cnt = 0;
  int m_ocnt = 0;
  always @(posedge clk) begin
    if (dut_rst) begin
      m_st <= 0; m_cnt <= 0; m_ocnt <= 0;
      enc_readyxSI <= 1'b0; ctxSI <= 1'b0; tagxSI <= 1'b0;
    end else begin
      case (m_st)
        0: if (enc_startxSO) begin m_st <= 1; m_cnt <= 0; end
        1: begin
          if (mode != 1) begin
            if (m_cnt == MDLY) begin enc_readyxSI <= 1'b1; m_st <= 2; m_ocnt <= 0; end
            else m_cnt <= m_cnt + 1;
          end
        end
        default: begin
          if (m_ocnt < 32) ctxSI <= CT[m_ocnt]; else ctxSI <= 1'b0;
          if (m_ocnt < 128) tagxSI <= TAGV[m_ocnt]; else tagxSI <= 1'b0;
          if (mode == 2 && m_ocnt == 40) enc_readyxSI <= 1'b0;
          m_ocnt <= m_ocnt + 1;
        end
      endcase
    end
  end

  task automatic chk(input string tg, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  // Per-job observations
  logic [127:0] key0_v;
  logic [31:0]  ad0_v, pt0_v, rst_ct;
  logic         rst_err;
  int  sidx, start_cnt, start_at, gap, busy_cyc;
  bit  tail_nz, side_nz, got_done, err_at_done, rst_seen;

  // Follows one job cycle by cycle at negedges until done (bounded).
  task automatic run_job(input bit hold, input bit change_pt);
    key0_v = '0; ad0_v = '0; pt0_v = '0; rst_ct = '1; rst_err = 1'b1;
    sidx = 0; start_cnt = 0; start_at = -1; gap = 0; busy_cyc = 0;
    tail_nz = 0; side_nz = 0; got_done = 0; err_at_done = 0; rst_seen = 0;
    for (int c = 0; c < 2000 && !got_done; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy) busy_cyc++;
      if (busy && dut_rst && !rst_seen) begin rst_seen = 1; rst_err = err; rst_ct = cipher_text; end
      if (busy && !dut_rst && start_cnt == 0 && !enc_startxSO) begin
        if (sidx < 128) key0_v[127-sidx] = keyxSO[0];
        else if (keyxSO != 3'b0) tail_nz = 1;
        if (sidx < 32) begin ad0_v[31-sidx] = adxSO[0]; pt0_v[31-sidx] = ptxSO[0]; end
        if (keyxSO[2:1] != 2'b0) side_nz = 1;
        if (change_pt && sidx == 10) pt_sh = ~pt_sh;
        sidx++;
      end else if (enc_startxSO) begin
        start_cnt++;
        if (start_at < 0) start_at = sidx;
      end else if (start_cnt > 0 && !done) begin
        gap++;
      end
      if (done) begin got_done = 1; err_at_done = err; end
    end
    chk("job_done_seen", 128'(got_done), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dut_rst", 128'(dut_rst), 128'd1);
    chk("rst_done_err", 128'({done, err}), 128'd0);
    chk("rst_ct", 128'(cipher_text), 128'd0);
    chk("rst_tag", tag, 128'd0);
    chk("rst_serial", 128'({keyxSO, noncexSO, adxSO, ptxSO, r64xSO, r128xSO, rptxSO, enc_startxSO}), 128'd0);
    rst = 1'b0;

    // Job A: basic stream ordering and normal result capture
    key_sh = {256'b0, KEY0};
    ad_sh  = {64'b0, 32'h0000_0001};
    @(negedge clk);
    start = 1'b1;
    run_job(0, 0);
    chk("A_key0_stream", key0_v, KEY0);
    chk("A_key0_tail_zero", 128'(tail_nz), 128'd0);
    chk("A_key_shares12_zero", 128'(side_nz), 128'd0);
    chk("A_ad0_stream", 128'(ad0_v), 128'h1);
    chk("A_shift_cycles", 128'(start_at), 128'd129);
    chk("A_start_pulse_len", 128'(start_cnt), 128'd1);
    chk("A_wait_recv_cycles", 128'(gap), 128'd133);
    chk("A_busy_cycles", 128'(busy_cyc), 128'd265);
    chk("A_err", 128'(err_at_done), 128'd0);
    chk("A_ct", 128'(cipher_text), 128'(CT));
    chk("A_tag", tag, TAGV);
    @(negedge clk);
    chk("A_done_single", 128'(done), 128'd0);
    chk("A_idle_busy_rst", 128'({busy, dut_rst}), 128'b01);

    // Job B: ready drops at result bit 40
    mode = 2;
    start = 1'b1;
    run_job(0, 0);
    chk("B_ct_cleared_at_rst_dut", 128'(rst_ct), 128'd0);
    chk("B_err", 128'(err_at_done), 128'd1);
    chk("B_abort_point", 128'(gap), 128'd46);
    chk("B_ct_full", 128'(cipher_text), 128'(CT));
    chk("B_tag_partial", tag, TAGV & 128'hFF_FFFF_FFFF);

    // Job C: ready never arrives
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    run_job(0, 0);
    chk("C_err_cleared_at_rst_dut", 128'(rst_err), 128'd0);
    chk("C_err", 128'(err_at_done), 128'd1);
    chk("C_wait_cycles", 128'(gap), 128'(TO));
    @(negedge clk);
    chk("C_err_held", 128'(err), 128'd1);

    // Job D: async reset mid-SHIFT, then a clean job
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (51) @(negedge clk);
    chk("D_in_shift", 128'({busy, dut_rst}), 128'b10);
    rst = 1'b1;
    #1;
    chk("D_rst_busy", 128'(busy), 128'd0);
    chk("D_rst_dut_rst", 128'(dut_rst), 128'd1);
    chk("D_rst_key_out", 128'(keyxSO), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    run_job(0, 0);
    chk("D_key0_stream", key0_v, KEY0);
    chk("D_err", 128'(err_at_done), 128'd0);
    chk("D_ct", 128'(cipher_text), 128'(CT));
    chk("D_tag", tag, TAGV);

    // Job E: start held, PT changed mid-SHIFT, back-to-back second job
    pt_sh = {64'b0, 32'hDEAD_BEEF};
    @(negedge clk);
    start = 1'b1;
    run_job(1, 1);
    chk("E_pt_latched", 128'(pt0_v), 128'hDEAD_BEEF);
    chk("E_busy_cycles", 128'(busy_cyc), 128'd265);
    chk("E_ct", 128'(cipher_text), 128'(CT));
    @(negedge clk);
    chk("E_idle_gap", 128'(busy), 128'd0);
    @(negedge clk);
    chk("E_second_rst_dut", 128'({busy, dut_rst}), 128'b11);
    start = 1'b0;
    run_job(0, 0);
    chk("E2_pt_new", 128'(pt0_v), 128'h2152_4110);
    chk("E2_ct", 128'(cipher_text), 128'(CT));
    chk("E2_tag", tag, TAGV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
